// File: rtl/man_frame_seq.sv
// rtl/man_frame_seq.sv - EM4100-style 64-bit frame sequencer with Manchester output
//
// Builds a 64-bit frame from a 40-bit ID:
//   9 header 1s | 10 x (4 data bits + even row parity) | 4 even column parities | stop 0
// The frame is paced at 2*HALF_BIT_DIV clocks per bit.
// Optional macro MAN_FRAME_SEQ_REPEAT_EN: continuous repetition with a shadow ID register.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   load        accept data_in when ready=1
//   data_in     40-bit ID, [39:36] is row 0, MSB first within a row
//   abort       synchronous abort of the current frame
//   ready       block can accept load
//   busy        frame in progress
//   tx_bit      current frame bit
//   bit_clk     1 in the first half-bit, 0 in the second
//   tx_man      Manchester symbol (tx_bit ? bit_clk : ~bit_clk), 0 when idle
//   frame_done  one-cycle pulse in the last clk of the stop bit
//   bit_idx     index 0..63 of the bit being sent
module man_frame_seq #(
  parameter int HALF_BIT_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [39:0] data_in,
  input  logic        abort,
  output logic        ready,
  output logic        busy,
  output logic        tx_bit,
  output logic        bit_clk,
  output logic        tx_man,
  output logic        frame_done,
  output logic [5:0]  bit_idx
);

  localparam int            DW       = $clog2(HALF_BIT_DIV) + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(HALF_BIT_DIV - 1);
  localparam logic [DW-1:0] DIV_PRE  = DW'(HALF_BIT_DIV - 2);
  localparam bit            DIV_ONE  = (HALF_BIT_DIV == 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CPAR, S_STOP} state_t;

  // Frame vector with f[i] = bit i on the line.
  function automatic logic [63:0] build_frame(input logic [39:0] id);
    logic [63:0] f;
    logic [3:0]  nib;
    logic [3:0]  col;
    f      = '0;
    col    = '0;
    f[8:0] = '1;
    for (int r = 0; r < 10; r++) begin
      nib = id[39-4*r -: 4];
      for (int k = 0; k < 4; k++) f[9+5*r+k] = nib[3-k];
      f[13+5*r] = ^nib;
      col       = col ^ nib;
    end
    for (int c = 0; c < 4; c++) f[59+c] = col[3-c];
    f[63] = 1'b0;
    return f;
  endfunction

  state_t        state_q, state_d;
  logic [63:0]   frame_q, frame_d;
  logic [DW-1:0] div_q, div_d;
  logic [5:0]    bit_idx_q, bit_idx_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic          tx_bit_q, tx_bit_d;
  logic          bit_clk_q, bit_clk_d;
  logic          tx_man_q, tx_man_d;
  logic          frame_done_q, frame_done_d;
  logic          half_end, bit_end, last_bit;
`ifdef MAN_FRAME_SEQ_REPEAT_EN
  logic [39:0]   shadow_q, shadow_d;
  logic          shadow_vld_q, shadow_vld_d;
`endif

  always_comb begin
    half_end     = (div_q == DIV_LAST);
    bit_end      = half_end && !bit_clk_q;   // bit_clk_q=0 marks the second half
    last_bit     = (bit_idx_q == 6'd63);
    frame_d      = frame_q;
    div_d        = div_q;
    bit_idx_d    = bit_idx_q;
    busy_d       = busy_q;
    bit_clk_d    = bit_clk_q;
    frame_done_d = 1'b0;
`ifdef MAN_FRAME_SEQ_REPEAT_EN
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
`endif
    if (state_q == S_IDLE) begin
      if (load && ready_q && !abort) begin
        frame_d   = build_frame(data_in);
        div_d     = '0;
        bit_idx_d = '0;
        busy_d    = 1'b1;
        bit_clk_d = 1'b1;
      end
    end else if (abort) begin
      div_d     = '0;
      bit_idx_d = '0;
      busy_d    = 1'b0;
      bit_clk_d = 1'b0;
`ifdef MAN_FRAME_SEQ_REPEAT_EN
      shadow_vld_d = 1'b0;
`endif
    end else begin
      div_d = div_q + DW'(1);
      if (half_end) begin
        div_d     = '0;
        bit_clk_d = ~bit_clk_q;
        if (bit_end) begin
          bit_clk_d = 1'b1;
          if (!last_bit) begin
            bit_idx_d = bit_idx_q + 6'd1;
          end else begin
`ifdef MAN_FRAME_SEQ_REPEAT_EN
            // Wrap straight into the next frame; a load arriving right now wins.
            bit_idx_d    = '0;
            shadow_vld_d = 1'b0;
            if (load)              frame_d = build_frame(data_in);
            else if (shadow_vld_q) frame_d = build_frame(shadow_q);
`else
            bit_idx_d = '0;
            busy_d    = 1'b0;
            bit_clk_d = 1'b0;
`endif
          end
        end
      end
`ifdef MAN_FRAME_SEQ_REPEAT_EN
      if (load && !(bit_end && last_bit)) begin
        shadow_d     = data_in;
        shadow_vld_d = 1'b1;
      end
`endif
      // Pulse is registered, so raise it when the next cycle is the last one of bit 63.
      frame_done_d = last_bit && (DIV_ONE ? (bit_clk_q && half_end)
                                          : (!bit_clk_q && div_q == DIV_PRE));
    end

    if (!busy_d)                 state_d = S_IDLE;
    else if (bit_idx_d < 6'd9)   state_d = S_HDR;
    else if (bit_idx_d < 6'd59)  state_d = S_DATA;
    else if (bit_idx_d < 6'd63)  state_d = S_CPAR;
    else                         state_d = S_STOP;

`ifdef MAN_FRAME_SEQ_REPEAT_EN
    ready_d  = 1'b1;
`else
    ready_d  = !busy_d;
`endif
    tx_bit_d = busy_d ? frame_d[bit_idx_d] : 1'b0;
    tx_man_d = busy_d & ~(tx_bit_d ^ bit_clk_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frame_q      <= '0;
      div_q        <= '0;
      bit_idx_q    <= '0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
      tx_bit_q     <= 1'b0;
      bit_clk_q    <= 1'b0;
      tx_man_q     <= 1'b0;
      frame_done_q <= 1'b0;
`ifdef MAN_FRAME_SEQ_REPEAT_EN
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      frame_q      <= frame_d;
      div_q        <= div_d;
      bit_idx_q    <= bit_idx_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
      tx_bit_q     <= tx_bit_d;
      bit_clk_q    <= bit_clk_d;
      tx_man_q     <= tx_man_d;
      frame_done_q <= frame_done_d;
`ifdef MAN_FRAME_SEQ_REPEAT_EN
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
`endif
    end
  end

  assign ready      = ready_q;
  assign busy       = busy_q;
  assign tx_bit     = tx_bit_q;
  assign bit_clk    = bit_clk_q;
  assign tx_man     = tx_man_q;
  assign frame_done = frame_done_q;
  assign bit_idx    = bit_idx_q;

endmodule

// File: doc/man_frame_seq.md
Name: man_frame_seq

Overview:
- Frame sequencer for the Manchester TX path of the RFID tag emulator.
- Takes a 40-bit ID and builds a 64-bit EM4100-style frame:
  - 9 header 1s.
  - 10 rows of 4 data bits, each followed by an even row parity bit.
  - 4 even column parity bits.
  - 1 stop bit (0).
- Paces the frame out at a programmable bit rate and drives the data/strobe pair into the Manchester encoder.
- Also emits a registered Manchester waveform directly.

Parameters:
- HALF_BIT_DIV, 32, clk cycles per half bit (bit period = 2*HALF_BIT_DIV; 32 gives RF/64 with clk = carrier). Legal range >= 1.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- load  in  1  request to accept data_in; takes effect only when ready=1.
- data_in  in  40  ID; [39:36] is row 0, MSB sent first within each row.
- abort  in  1  synchronous abort of the current frame.
- ready  out  1  block can accept load.
- busy  out  1  frame in progress.
- tx_bit  out  1  current frame bit (encoder data input).
- bit_clk  out  1  bit strobe: 1 in the first half-bit, 0 in the second.
- tx_man  out  1  Manchester symbol: tx_bit ? bit_clk : ~bit_clk.
- frame_done  out  1  one-cycle pulse on the last clk of the stop bit.
- bit_idx  out  6  index 0..63 of the bit being sent.

Behaviour:
- Reset values (rst=1 at a posedge): ready=1, busy=0, tx_bit=0, bit_clk=0, tx_man=0, frame_done=0, bit_idx=0. Reset also clears the divider and the shift/parity state.
- Reset mid-frame aborts with no further symbols; outputs reach reset values on the next cycle.
- All outputs are registered.
- States:
  - IDLE -> HDR on load&&ready.
  - HDR, 9 bits -> DATA.
  - DATA, 50 bits: rows r=0..9 send d[39-4r..36-4r] then the row parity -> CPAR.
  - CPAR, 4 bits: column c = XOR of bit (3-c) of all 10 nibbles, sent c=0..3 -> STOP.
  - STOP, 1 bit, value 0 -> IDLE.
- Handshake and latency:
  - load&&ready at edge N latches data_in, computes all parities into a 64-bit frame register, and sets ready=0.
  - From edge N+1: busy=1, bit_idx=0, tx_bit=1, bit_clk=1.
  - Each bit lasts exactly 2*HALF_BIT_DIV cycles; bit_clk falls after HALF_BIT_DIV cycles.
  - bit_idx and tx_bit change only at bit boundaries, together with the bit_clk rising edge.
- Frame end (non-repeat):
  - frame_done=1 in the last cycle of bit 63.
  - Next cycle: busy=0, ready=1, tx_bit=0, bit_clk=0, tx_man=0.
  - A load in that same cycle is accepted, giving the next frame with a one-cycle idle gap.
- Idle: tx_man=0 (line quiet).
- load while ready=0: ignored, no latching.
- abort (not rst):
  - Next cycle: IDLE with reset output values, except ready=1.
  - No frame_done pulse.
  - abort has priority over load in the same cycle.
  - abort in IDLE is a no-op.
- HALF_BIT_DIV=1: bit_clk alternates every cycle.
- Divider counter width is clog2(HALF_BIT_DIV)+1. It wraps to 0 at each half-bit boundary; no overflow is possible.

Optional Feature:
- Macro MAN_FRAME_SEQ_REPEAT_EN.
- Defined (continuous tag emulation):
  - ready stays 1 while busy.
  - A load accepted during a frame goes into a shadow register and does not disturb the current frame.
  - At the end of bit 63, frame_done pulses, and the next cycle starts bit 0 of the next frame with no gap. busy stays 1.
  - The next frame uses the shadow data if a load was accepted during the frame, otherwise it repeats the current data.
  - Only abort or rst return the block to IDLE.
- Undefined: behaviour exactly as described above; no shadow register.

Test Plan:
- HALF_BIT_DIV=2, load data_in=40'h0: bits 0-8 = 1, bits 9-63 = 0.
  - frame_done at the 256th cycle after acceptance; busy=0 and ready=1 next cycle.
  - tx_man = 1,1,0,0 per header bit and 0,0,1,1 per 0-bit.
- load 40'hFFFFFFFF_FF: every row = 11110, column parity = 0000, stop = 0. Check bit_idx 9..58 pattern and bit_idx 63 = 0.
- load 40'h10_0000_0000: row 0 = 0001 with parity 1, other rows 00000, column parity bits 59..62 = 0,0,0,1.
- Assert load again while busy (non-repeat) with 40'hAA..: ignored; the frame carries the original data. Assert abort at bit_idx 20: next cycle busy=0, tx_man=0, no frame_done.
- Assert rst at bit_idx 30 mid-half-bit: next cycle all outputs at reset values. load 1 cycle after rst deasserts starts a full frame from bit 0.
- With MAN_FRAME_SEQ_REPEAT_EN:
  - load A, then load B during frame 1.
  - frame 2 = B, starting the cycle after frame_done with no gap.
  - No further load: frame 3 = B.
  - abort: IDLE next cycle.
